axi_read_arbiter: RTL and testbench

//  Shares one AXI read slave (e.g. the IM SRAM slave) between two read masters:
//   M0 = CPU instruction fetch, M1 = CPU data load.

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/axi_read_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and AXI field widths for the read (and later write) arbiters
// that put two CPU masters onto one AXI slave.
package axi_arb_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_t;
    typedef enum logic {GNT_M0, GNT_M1} gnt_t;

    function automatic gnt_t other_master(input gnt_t g);
        return (g == GNT_M0) ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes to prio.
module rr_pick2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       prio,
    output gnt_t       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = prio;
        if (req == 2'b01) begin
            gnt = GNT_M0;
        end else if (req == 2'b10) begin
            gnt = GNT_M1;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read slave between instruction fetch (M0) and data load (M1);
// the grant is held from the AR handshake until the RLAST beat handshakes.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter logic [3:0] M0_IDX = 4'h0,
    parameter logic [3:0] M1_IDX = 4'h1
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,

    input  logic [AXI_ID_BITS-1:0]   ARID_M0,
    input  logic [31:0]              ARADDR_M0,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]               ARBURST_M0,
    input  logic                     ARVALID_M0,
    output logic                     ARREADY_M0,
    output logic [AXI_ID_BITS-1:0]   RID_M0,
    output logic [31:0]              RDATA_M0,
    output logic [1:0]               RRESP_M0,
    output logic                     RLAST_M0,
    output logic                     RVALID_M0,
    input  logic                     RREADY_M0,

    input  logic [AXI_ID_BITS-1:0]   ARID_M1,
    input  logic [31:0]              ARADDR_M1,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_M1,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]               ARBURST_M1,
    input  logic                     ARVALID_M1,
    output logic                     ARREADY_M1,
    output logic [AXI_ID_BITS-1:0]   RID_M1,
    output logic [31:0]              RDATA_M1,
    output logic [1:0]               RRESP_M1,
    output logic                     RLAST_M1,
    output logic                     RVALID_M1,
    input  logic                     RREADY_M1,

    output logic [AXI_IDS_BITS-1:0]  ARID_S,
    output logic [31:0]              ARADDR_S,
    output logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    output logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
    output logic [1:0]               ARBURST_S,
    output logic                     ARVALID_S,
    input  logic                     ARREADY_S,
    input  logic [AXI_IDS_BITS-1:0]  RID_S,
    input  logic [31:0]              RDATA_S,
    input  logic [1:0]               RRESP_S,
    input  logic                     RLAST_S,
    input  logic                     RVALID_S,
    output logic                     RREADY_S
);

    arb_state_t               state_q, state_d;
    gnt_t                     grant_q, grant_d;
    gnt_t                     prio_q, prio_d;
    logic [AXI_LEN_BITS-1:0]  beat_cnt_q, beat_cnt_d;
    logic [AXI_LEN_BITS-1:0]  exp_len_q, exp_len_d;
    logic                     err_q, err_d;

    gnt_t                     pick_gnt;
    logic                     pick_valid;

    logic [AXI_ID_BITS-1:0]   gm_arid;
    logic [31:0]              gm_araddr;
    logic [AXI_LEN_BITS-1:0]  gm_arlen;
    logic [AXI_SIZE_BITS-1:0] gm_arsize;
    logic [1:0]               gm_arburst;
    logic                     gm_arvalid;
    logic                     gm_rready;
    logic [3:0]               gm_idx;
    logic                     ar_hs;
    logic                     r_hs;

    rr_pick2 u_pick (
        .req   ({ARVALID_M1, ARVALID_M0}),
        .prio  (prio_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Fields of whichever master currently holds the grant.
    always_comb begin
        if (grant_q == GNT_M1) begin
            gm_arid    = ARID_M1;
            gm_araddr  = ARADDR_M1;
            gm_arlen   = ARLEN_M1;
            gm_arsize  = ARSIZE_M1;
            gm_arburst = ARBURST_M1;
            gm_arvalid = ARVALID_M1;
            gm_rready  = RREADY_M1;
            gm_idx     = M1_IDX;
        end else begin
            gm_arid    = ARID_M0;
            gm_araddr  = ARADDR_M0;
            gm_arlen   = ARLEN_M0;
            gm_arsize  = ARSIZE_M0;
            gm_arburst = ARBURST_M0;
            gm_arvalid = ARVALID_M0;
            gm_rready  = RREADY_M0;
            gm_idx     = M0_IDX;
        end
    end

    assign ar_hs = (state_q == ADDR) && gm_arvalid && ARREADY_S;
    assign r_hs  = (state_q == DATA) && RVALID_S && gm_rready;

    // NOTE: every output gets a value before the case so no path infers a latch.
    always_comb begin
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        ARVALID_S  = 1'b0;
        RREADY_S   = 1'b0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        RID_M0     = '0;
        RDATA_M0   = '0;
        RRESP_M0   = RESP_OKAY;
        RLAST_M0   = 1'b0;
        RVALID_M0  = 1'b0;
        RID_M1     = '0;
        RDATA_M1   = '0;
        RRESP_M1   = RESP_OKAY;
        RLAST_M1   = 1'b0;
        RVALID_M1  = 1'b0;
        case (state_q)
            ADDR: begin
                ARID_S    = {gm_idx, gm_arid};
                ARADDR_S  = gm_araddr;
                ARLEN_S   = gm_arlen;
                ARSIZE_S  = gm_arsize;
                ARBURST_S = gm_arburst;
                ARVALID_S = gm_arvalid;
                if (grant_q == GNT_M1) ARREADY_M1 = ARREADY_S;
                else                   ARREADY_M0 = ARREADY_S;
            end
            DATA: begin
                RREADY_S = gm_rready;
                if (grant_q == GNT_M1) begin
                    RID_M1    = RID_S[AXI_ID_BITS-1:0];
                    RDATA_M1  = RDATA_S;
                    RRESP_M1  = RRESP_S;
                    RLAST_M1  = RLAST_S;
                    RVALID_M1 = RVALID_S;
                end else begin
                    RID_M0    = RID_S[AXI_ID_BITS-1:0];
                    RDATA_M0  = RDATA_S;
                    RRESP_M0  = RRESP_S;
                    RLAST_M0  = RLAST_S;
                    RVALID_M0 = RVALID_S;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        prio_d     = prio_q;
        beat_cnt_d = beat_cnt_q;
        exp_len_d  = exp_len_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    exp_len_d  = gm_arlen;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
                    if (RID_S[AXI_IDS_BITS-1:AXI_ID_BITS] != gm_idx) err_d = 1'b1;
                    if (RLAST_S) begin
                        if (beat_cnt_q != exp_len_q) err_d = 1'b1;
                        prio_d  = other_master(grant_q);
                        state_d = IDLE;
                    end else if (beat_cnt_q >= exp_len_q) begin
                        // A non-last beat at or past the announced length overruns the burst.
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            grant_q    <= GNT_M0;
            prio_q     <= GNT_M0;
            beat_cnt_q <= '0;
            exp_len_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            prio_q     <= prio_d;
            beat_cnt_q <= beat_cnt_d;
            exp_len_q  <= exp_len_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a vector table of read transactions
// plus hand-written arbitration, stall and mid-burst reset sequences.
module tb_axi_read_arbiter;
    import axi_arb_pkg::*;

    logic        ACLK;
    logic        ARESETn;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1;
    logic        RVALID_M0, RVALID_M1;
    logic        RREADY_M0, RREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;

    int checks = 0;
    int errors = 0;

    axi_read_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [7:0]  rid_s;
        logic [31:0] rdata;
        int          last_at;
        bit          toggle;
        logic [7:0]  exp_arid;
        bit          exp_err;
        bit          rst_before;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ar(input bit m, input logic v, input logic [3:0] id,
                          input logic [31:0] addr, input logic [3:0] len);
        if (m) begin
            ARVALID_M1 = v; ARID_M1 = id; ARADDR_M1 = addr; ARLEN_M1 = len;
        end else begin
            ARVALID_M0 = v; ARID_M0 = id; ARADDR_M0 = addr; ARLEN_M0 = len;
        end
    endtask

    task automatic idle_inputs();
        set_ar(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        set_ar(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
        ARSIZE_M0 = 3'b010; ARBURST_M0 = 2'b01;
        ARSIZE_M1 = 3'b010; ARBURST_M1 = 2'b01;
        RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        ARREADY_S = 1'b1;
        RID_S = 8'h00; RDATA_S = 32'h0; RRESP_S = 2'b00; RLAST_S = 1'b0; RVALID_S = 1'b0;
    endtask

    // Leaves the bench at a negedge with the DUT idle and reset released.
    task automatic apply_reset();
        @(negedge ACLK);
        idle_inputs();
        ARVALID_M0 = 1'b1;
        ARESETn = 1'b0;
        #1;
        check("rst/arvalid_s", ARVALID_S, 1'b0);
        check("rst/arready_m0", ARREADY_M0, 1'b0);
        check("rst/rready_s", RREADY_S, 1'b0);
        check("rst/arid_s", ARID_S, 8'h00);
        check("rst/state", dut.state_q, IDLE);
        check("rst/prio", dut.prio_q, GNT_M0);
        check("rst/err", dut.err_q, 1'b0);
        @(negedge ACLK);
        ARVALID_M0 = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    // One read: AR phase on master m, then slave beats 0..last_at with RLAST on the final one.
    task automatic do_read(input string tag, input vec_t v);
        int  beat;
        int  cyc;
        bit  rr;
        logic [31:0] exp_data;
        set_ar(v.m, 1'b1, v.id, v.addr, v.len);
        #1;
        check({tag, "/ar_latency"}, ARVALID_S, 1'b0);
        @(negedge ACLK);
        #1;
        check({tag, "/arvalid_s"}, ARVALID_S, 1'b1);
        check({tag, "/arid_s"}, ARID_S, v.exp_arid);
        check({tag, "/araddr_s"}, ARADDR_S, v.addr);
        check({tag, "/arlen_s"}, ARLEN_S, v.len);
        check({tag, "/arsize_s"}, {ARBURST_S, ARSIZE_S}, 5'b01_010);
        check({tag, "/arready_gnt"}, v.m ? ARREADY_M1 : ARREADY_M0, 1'b1);
        check({tag, "/arready_oth"}, v.m ? ARREADY_M0 : ARREADY_M1, 1'b0);
        @(negedge ACLK);
        set_ar(v.m, 1'b0, v.id, v.addr, v.len);
        beat = 0;
        cyc  = 0;
        rr   = !v.toggle;
        while (beat <= v.last_at && cyc < 40) begin
            if (v.m) RREADY_M1 = rr; else RREADY_M0 = rr;
            exp_data = v.rdata + beat;
            RVALID_S = 1'b1;
            RID_S    = v.rid_s;
            RDATA_S  = exp_data;
            RLAST_S  = (beat == v.last_at);
            #1;
            check({tag, "/rvalid_gnt"}, v.m ? RVALID_M1 : RVALID_M0, 1'b1);
            check({tag, "/rvalid_oth"}, v.m ? RVALID_M0 : RVALID_M1, 1'b0);
            check({tag, "/rdata"}, v.m ? RDATA_M1 : RDATA_M0, exp_data);
            check({tag, "/rid_m"}, v.m ? RID_M1 : RID_M0, v.rid_s & 8'h0f);
            check({tag, "/rlast_m"}, v.m ? RLAST_M1 : RLAST_M0, beat == v.last_at);
            check({tag, "/rready_s"}, RREADY_S, rr);
            check({tag, "/arvalid_s_data"}, ARVALID_S, 1'b0);
            if (rr) begin
                check({tag, "/beat_cnt"}, dut.beat_cnt_q, beat);
                beat++;
            end
            @(negedge ACLK);
            if (v.toggle) rr = !rr;
            cyc++;
        end
        check({tag, "/beats"}, beat, v.last_at + 1);
        RVALID_S = 1'b0; RLAST_S = 1'b0;
        RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        #1;
        check({tag, "/state_end"}, dut.state_q, IDLE);
        check({tag, "/rvalid_end"}, v.m ? RVALID_M1 : RVALID_M0, 1'b0);
        check({tag, "/err"}, dut.err_q, v.exp_err);
        @(negedge ACLK);
    endtask

    initial begin
        vec_t v;
        bit   g;
        ARESETn = 1'b0;
        idle_inputs();

        //        m     id    addr           len   rid    rdata          last tog arid   err rst
        vecs[0] = '{1'b0, 4'h3, 32'h0000_0010, 4'd0, 8'h03, 32'hDEAD_BEEF, 0, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'hA, 32'h0000_0020, 4'd0, 8'h1A, 32'h1234_5678, 0, 1'b0, 8'h1A, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 4'hF, 32'h0000_1000, 4'd0, 8'h0F, 32'hFFFF_FFFF, 0, 1'b1, 8'h0F, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'h0, 32'hFFFF_FFFC, 4'd3, 8'h10, 32'hB000_0000, 3, 1'b1, 8'h10, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'h5, 32'h0000_0040, 4'd0, 8'h15, 32'hCAFE_F00D, 0, 1'b0, 8'h05, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'h2, 32'h0000_0050, 4'd1, 8'h12, 32'h0000_0100, 0, 1'b0, 8'h12, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 4'h1, 32'h0000_0060, 4'd0, 8'h01, 32'h0000_0200, 2, 1'b0, 8'h01, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 4'hE, 32'h0000_0070, 4'd2, 8'h1E, 32'h0000_0300, 2, 1'b0, 8'h1E, 1'b0, 1'b1};

        apply_reset();
        @(negedge ACLK);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst_before) begin
                apply_reset();
                @(negedge ACLK);
            end
            do_read($sformatf("vec%0d", i), vecs[i]);
        end

        // Both masters request continuously: grants alternate starting with M0.
        apply_reset();
        @(negedge ACLK);
        set_ar(1'b0, 1'b1, 4'h2, 32'h0000_0A00, 4'd0);
        set_ar(1'b1, 1'b1, 4'h7, 32'h0000_0B00, 4'd0);
        g = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            #1;
            check($sformatf("arb%0d/arid_s", k), ARID_S, g ? 8'h17 : 8'h02);
            check($sformatf("arb%0d/araddr_s", k), ARADDR_S, g ? 32'h0000_0B00 : 32'h0000_0A00);
            check($sformatf("arb%0d/arready_oth", k), g ? ARREADY_M0 : ARREADY_M1, 1'b0);
            @(negedge ACLK);
            RVALID_S = 1'b1; RLAST_S = 1'b1;
            RID_S    = g ? 8'h17 : 8'h02;
            RDATA_S  = 32'h5000_0000 + k;
            #1;
            check($sformatf("arb%0d/rvalid_gnt", k), g ? RVALID_M1 : RVALID_M0, 1'b1);
            check($sformatf("arb%0d/rvalid_oth", k), g ? RVALID_M0 : RVALID_M1, 1'b0);
            check($sformatf("arb%0d/arready_hold", k), g ? ARREADY_M0 : ARREADY_M1, 1'b0);
            @(negedge ACLK);
            RVALID_S = 1'b0; RLAST_S = 1'b0;
            if (k == 3) begin
                ARVALID_M0 = 1'b0;
                ARVALID_M1 = 1'b0;
            end
            g = !g;
        end
        check("arb/err", dut.err_q, 1'b0);

        // Slave stalls AR for 5 cycles; the master drops ARVALID in one of them.
        @(negedge ACLK);
        ARREADY_S = 1'b0;
        set_ar(1'b0, 1'b1, 4'h6, 32'h0000_0ABC, 4'd0);
        @(negedge ACLK);
        for (int i = 0; i < 5; i++) begin
            ARVALID_M0 = (i != 2);
            RVALID_S = 1'b1; RLAST_S = 1'b1; RID_S = 8'h06; RDATA_S = 32'hBAD0_0000;
            #1;
            check($sformatf("stall%0d/arvalid_s", i), ARVALID_S, i != 2);
            check($sformatf("stall%0d/araddr_s", i), ARADDR_S, 32'h0000_0ABC);
            check($sformatf("stall%0d/arid_s", i), ARID_S, 8'h06);
            check($sformatf("stall%0d/arready_m0", i), ARREADY_M0, 1'b0);
            check($sformatf("stall%0d/rvalid_m0", i), RVALID_M0, 1'b0);
            check($sformatf("stall%0d/rready_s", i), RREADY_S, 1'b0);
            @(negedge ACLK);
        end
        RVALID_S = 1'b0; RLAST_S = 1'b0;
        ARVALID_M0 = 1'b1;
        ARREADY_S = 1'b1;
        #1;
        check("stall/arready_m0", ARREADY_M0, 1'b1);
        @(negedge ACLK);
        ARVALID_M0 = 1'b0;
        RVALID_S = 1'b1; RLAST_S = 1'b1; RDATA_S = 32'h0000_0ABC;
        #1;
        check("stall/rdata_m0", RDATA_M0, 32'h0000_0ABC);
        @(negedge ACLK);
        RVALID_S = 1'b0; RLAST_S = 1'b0;
        #1;
        check("stall/state_end", dut.state_q, IDLE);

        // Reset asserted during beat 2 of a 4-beat M1 burst.
        @(negedge ACLK);
        set_ar(1'b1, 1'b1, 4'h9, 32'h0000_0300, 4'd3);
        @(negedge ACLK);
        @(negedge ACLK);
        set_ar(1'b1, 1'b0, 4'h9, 32'h0000_0300, 4'd3);
        for (int b = 0; b < 2; b++) begin
            RVALID_S = 1'b1; RID_S = 8'h19; RDATA_S = 32'h7000_0000 + b;
            @(negedge ACLK);
        end
        RDATA_S = 32'h7000_0002;
        #1;
        check("midrst/rvalid_before", RVALID_M1, 1'b1);
        ARESETn = 1'b0;
        #1;
        check("midrst/rvalid_m1", RVALID_M1, 1'b0);
        check("midrst/rdata_m1", RDATA_M1, 32'h0);
        check("midrst/rid_m1", RID_M1, 4'h0);
        check("midrst/rready_s", RREADY_S, 1'b0);
        check("midrst/state", dut.state_q, IDLE);
        check("midrst/beat_cnt", dut.beat_cnt_q, 4'd0);
        RVALID_S = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        v = '{1'b1, 4'h4, 32'h0000_0400, 4'd1, 8'h14, 32'h0000_0800, 1, 1'b0, 8'h14, 1'b0, 1'b0};
        do_read("post_rst", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
